// File: rtl/score_pkg.sv
// Shared types and constants for the 3-digit score display controller.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONVERT  = 2'd1,
        WAIT_WIN = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    localparam int SCORE_MAX   = 999;
    localparam int NUM_DIGITS  = 3;
    localparam int BCD_W       = 12;
    localparam int CONV_CYCLES = 10;

    // Double-dabble correction: a nibble >= 5 would overflow past 9 after the shift.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [9:0] sat_score(input logic [9:0] bin);
        return (bin > 10'(SCORE_MAX)) ? 10'(SCORE_MAX) : bin;
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative 10-bit binary to 3-digit BCD converter, one shift per cycle.
module bin2bcd_iter
    import score_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [9:0]       bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    logic [9:0]       sr_p0;
    logic [3:0]       cnt;
    logic             run;
    logic [BCD_W-1:0] adj;

    assign adj  = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    assign done = run && (cnt == 4'(CONV_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
        end else if (run) begin
            if (cnt == 4'(CONV_CYCLES - 1))
                run <= 1'b0;
            cnt <= cnt + 4'd1;
        end
    end

    // Datapath: binary MSB shifts into the corrected BCD accumulator
    always_ff @(posedge clk) begin
        if (start) begin
            sr_p0 <= sat_score(bin);
            bcd   <= '0;
        end else if (run) begin
            bcd   <= {adj[BCD_W-2:0], sr_p0[9]};
            sr_p0 <= {sr_p0[8:0], 1'b0};
        end
    end

endmodule

// File: rtl/score_digit_ctrl.sv
// Renders a 3-digit decimal score through one shared digit sprite, committing
// new digits only while the scan is outside the score rows.
module score_digit_ctrl
    import score_pkg::*;
#(
    parameter int X_POS    = 0,
    parameter int Y_POS    = 0,
    parameter int DIGIT_W  = 10,
    parameter int DIGIT_H  = 12,
    parameter int GAP      = 2,
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [8:0] xvga,
    input  logic [7:0] yvga,
    input  logic [9:0] score,
    input  logic       load,
    output logic       busy,
    output logic [3:0] sprite_x,
    output logic [3:0] sprite_y,
    output logic [3:0] number,
    input  logic [2:0] sprite_color,
    output logic [2:0] color,
    output logic       pixel_on
);

    localparam logic [9:0] XP    = 10'(X_POS);
    localparam logic [9:0] YP    = 10'(Y_POS);
    localparam logic [9:0] DW    = 10'(DIGIT_W);
    localparam logic [9:0] DH    = 10'(DIGIT_H);
    localparam logic [9:0] PITCH = 10'(DIGIT_W + GAP);

    state_t           state;
    logic [BCD_W-1:0] disp;
    logic [BCD_W-1:0] bcd;
    logic             conv_done;
    logic             start;

    logic [9:0]       x10;
    logic [9:0]       y10;
    logic [9:0]       left;
    logic             y_in_p0;
    logic             in_win_p0;
    logic             blank_p0;
    logic [1:0]       sel_p0;

    assign start = (state == IDLE) && load;
    assign busy  = (state != IDLE);

    bin2bcd_iter u_conv (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .bin    (score),
        .bcd    (bcd),
        .done   (conv_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            disp  <= '0;
        end else begin
            case (state)
                IDLE:     if (load) state <= CONVERT;
                CONVERT:  if (conv_done) state <= WAIT_WIN;
                WAIT_WIN: if (!y_in_p0) state <= COMMIT;
                COMMIT: begin
                    disp  <= bcd;
                    state <= IDLE;
                end
                default:  state <= IDLE;
            endcase
        end
    end

    // Stage 0: decode which digit box the scan is in
    assign x10     = {1'b0, xvga};
    assign y10     = {2'b0, yvga};
    assign y_in_p0 = (y10 >= YP) && (y10 < YP + DH);

    always_comb begin
        in_win_p0 = 1'b0;
        sel_p0    = 2'd0;
        sprite_x  = 4'd0;
        left      = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            left = XP + 10'(k) * PITCH;
            if (y_in_p0 && (x10 >= left) && (x10 < left + DW)) begin
                in_win_p0 = 1'b1;
                sel_p0    = 2'(k);
                sprite_x  = 4'(x10 - left);
            end
        end
    end

    always_comb begin
        sprite_y = 4'd0;
        number   = 4'd0;
        if (in_win_p0) begin
            sprite_y = 4'(y10 - YP);
            case (sel_p0)
                2'd0:    number = disp[11:8];
                2'd1:    number = disp[7:4];
                default: number = disp[3:0];
            endcase
        end
    end

    // Leading-zero blanking; the units digit is always shown
    assign blank_p0 = (BLANK_LZ != 0) &&
                      (((sel_p0 == 2'd0) && (disp[11:8] == 4'd0)) ||
                       ((sel_p0 == 2'd1) && (disp[11:4] == 8'd0)));

    // Stage 1: aligned with the sprite ROM's one-cycle latency
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            pixel_on <= 1'b0;
        else
            pixel_on <= in_win_p0 & ~blank_p0;
    end

    assign color = pixel_on ? sprite_color : 3'b000;

endmodule

// File: tb/tb_score_digit_ctrl.sv
// Bench for score_digit_ctrl: decimal-level reference model plus directed scenarios.
module tb_score_digit_ctrl;

    localparam int XP = 0, YP = 0, DW = 10, DH = 12, GP = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [8:0] xvga = '0;
    logic [7:0] yvga = 8'd100;
    logic [9:0] score = '0;
    logic       load = 1'b0;
    logic       busy;
    logic [3:0] sprite_x, sprite_y, number;
    logic [2:0] sprite_color = '0;
    logic [2:0] color;
    logic       pixel_on;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: displayed value as a decimal integer
    int m_disp = 0, m_pend = 0, m_cnt = 0;
    bit m_busy = 0, m_armed = 0, m_pix = 0;

    score_digit_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .xvga         (xvga),
        .yvga         (yvga),
        .score        (score),
        .load         (load),
        .busy         (busy),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .number       (number),
        .sprite_color (sprite_color),
        .color        (color),
        .pixel_on     (pixel_on)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void decode(input int x, input int y, output bit win,
                                   output int k, output int sx, output int sy);
        win = 0; k = 0; sx = 0; sy = 0;
        if (y >= YP && y < YP + DH) begin
            for (int kk = 0; kk < 3; kk++) begin
                int lft;
                lft = XP + kk * (DW + GP);
                if (x >= lft && x < lft + DW) begin
                    win = 1; k = kk; sx = x - lft; sy = y - YP;
                end
            end
        end
    endfunction

    function automatic int digit_of(input int val, input int k);
        if (k == 0) return val / 100;
        if (k == 1) return (val / 10) % 10;
        return val % 10;
    endfunction

    function automatic bit shown(input int x, input int y, input int val);
        bit win; int k, sx, sy;
        decode(x, y, win, k, sx, sy);
        if (!win) return 0;
        if (k == 0 && val < 100) return 0;
        if (k == 1 && val < 10) return 0;
        return 1;
    endfunction

    // Model: conversion takes 10 edges, then commits on the edge after the
    // first later edge that sees the scan outside the score rows.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_disp = 0; m_busy = 0; m_armed = 0; m_pix = 0; m_cnt = 0;
        end else begin
            m_pix = shown(int'(xvga), int'(yvga), m_disp);
            if (!m_busy) begin
                if (load) begin
                    m_busy = 1;
                    m_pend = (int'(score) > 999) ? 999 : int'(score);
                    m_cnt  = 0;
                end
            end else begin
                m_cnt++;
                if (m_armed) begin
                    m_disp = m_pend; m_busy = 0; m_armed = 0;
                end else if (m_cnt >= 11 && !(int'(yvga) >= YP && int'(yvga) < YP + DH)) begin
                    m_armed = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit win; int k, sx, sy;
        decode(int'(xvga), int'(yvga), win, k, sx, sy);
        chk("busy", int'(busy), int'(m_busy));
        chk("pixel_on", int'(pixel_on), int'(m_pix));
        chk("color", int'(color), m_pix ? int'(sprite_color) : 0);
        chk("sprite_x", int'(sprite_x), sx);
        chk("sprite_y", int'(sprite_y), sy);
        chk("number", int'(number), win ? digit_of(m_disp, k) : 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
        sprite_color = sprite_color + 3'd3;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", int'(busy), 0);
    endtask

    task automatic do_load(input int s);
        score = 10'(s);
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        int cnt_on;
        int n;
        repeat (3) step();
        resetn = 1'b1;
        step();
        chk("reset_busy", int'(busy), 0);
        chk("reset_pixel_on", int'(pixel_on), 0);

        // Scan the window with value 0: only the units box lights
        cnt_on = 0;
        for (int y = 0; y < 14; y++) begin
            for (int x = 0; x < 41; x++) begin
                xvga = 9'(x); yvga = 8'(y);
                step();
                if (pixel_on) cnt_on++;
            end
        end
        chk("scan_on_count", cnt_on, 120);

        // 507 loaded outside the window
        xvga = 0; yvga = 100;
        do_load(507);
        chk("busy_rise", int'(busy), 1);
        n = 0;
        while (busy && n < 50) begin
            n++;
            step();
        end
        chk("latency_507", n, 12);
        xvga = 12; yvga = 3;
        step();
        chk("mid_zero_number", int'(number), 0);
        chk("mid_zero_on", int'(pixel_on), 1);
        xvga = 0; step();
        chk("hund_507", int'(number), 5);
        xvga = 24; step();
        chk("units_507", int'(number), 7);

        // Saturation
        yvga = 100;
        do_load(1023);
        wait_idle();
        xvga = 0; yvga = 0;
        step();
        chk("sat_hund", int'(number), 9);
        chk("sat_on", int'(pixel_on), 1);

        // Load inside the window: held until rows are left
        yvga = 5;
        do_load(42);
        repeat (20) step();
        chk("hold_busy", int'(busy), 1);
        xvga = 24; step();
        chk("hold_old_units", int'(number), 9);
        do_load(500);
        yvga = 12;
        wait_idle();
        repeat (3) step();
        chk("no_queue_busy", int'(busy), 0);
        xvga = 24; yvga = 3; step();
        chk("units_42", int'(number), 2);
        xvga = 0; step();
        chk("hund_42_blank", int'(pixel_on), 0);

        // Pixel alignment and gaps
        xvga = 13; yvga = 3; step();
        chk("align_sx", int'(sprite_x), 1);
        chk("align_sy", int'(sprite_y), 3);
        chk("align_num", int'(number), 4);
        chk("align_on", int'(pixel_on), 1);
        xvga = 10; step();
        chk("gap10_on", int'(pixel_on), 0);
        xvga = 11; step();
        chk("gap11_on", int'(pixel_on), 0);

        // Asynchronous reset in the middle of conversion
        xvga = 24; yvga = 3;
        step();
        chk("pre_reset_on", int'(pixel_on), 1);
        do_load(77);
        repeat (4) step();
        chk("pre_reset_busy", int'(busy), 1);
        resetn = 1'b0;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_on", int'(pixel_on), 0);
        chk("async_color", int'(color), 0);
        repeat (2) step();
        resetn = 1'b1;
        step();
        chk("post_reset_units", int'(number), 0);
        yvga = 100;
        do_load(77);
        wait_idle();
        xvga = 12; yvga = 3; step();
        chk("tens_77", int'(number), 7);
        xvga = 0; step();
        chk("hund_77_blank", int'(pixel_on), 0);
        xvga = 24; step();
        chk("units_77", int'(number), 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
